mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/line_assembler.sv | 53 +++++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared defaults and state types for the memory arbiter
package mem_arb_pkg;

    localparam int MEM_WORD_W = 32;
    localparam int MEM_ADDR_W = 6;
    localparam int MEM_BEATS  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_D = 1'b0,
        GRANT_I = 1'b1
    } grant_t;

endpackage

// File: rtl/line_assembler.sv
// rtl/line_assembler.sv - beat counter and line buffer for instruction-cache fills
module line_assembler
    import mem_arb_pkg::*;
#(
    parameter int WORD_W = MEM_WORD_W,
    parameter int BEATS  = MEM_BEATS,
    parameter int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     capture,
    input  logic                     deliver,
    input  logic [WORD_W-1:0]        word_in,
    output logic [BEAT_W-1:0]        beat,
    output logic                     last_beat,
    output logic [WORD_W*BEATS-1:0]  line
);

    logic [WORD_W-1:0]        slots [BEATS];
    logic [WORD_W*BEATS-1:0]  held;
    logic [WORD_W*BEATS-1:0]  assembled;

    // The final word bypasses the buffer so the line is usable in its completion cycle.
    always_comb begin
        assembled = '0;
        for (int s = 0; s < BEATS - 1; s++) begin
            assembled[s*WORD_W +: WORD_W] = slots[s];
        end
        assembled[(BEATS-1)*WORD_W +: WORD_W] = word_in;
    end

    assign last_beat = (beat == BEAT_W'(BEATS - 1));
    assign line      = deliver ? assembled : held;

    always_ff @(posedge clk) begin
        if (reset) begin
            beat <= '0;
            held <= '0;
            for (int s = 0; s < BEATS; s++) begin
                slots[s] <= '0;
            end
        end else begin
            if (capture) begin
                slots[beat] <= word_in;
                beat        <= last_beat ? '0 : beat + BEAT_W'(1);
            end
            if (deliver) begin
                held <= assembled;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between D and I caches
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORD_W = MEM_WORD_W,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int BEATS  = MEM_BEATS
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     d_read,
    input  logic                     d_write,
    input  logic [ADDR_W-1:0]        d_address,
    input  logic [WORD_W-1:0]        d_writedata,
    output logic [WORD_W-1:0]        d_readdata,
    output logic                     d_busywait,
    input  logic                     i_read,
    input  logic [ADDR_W-3:0]        i_address,
    output logic [WORD_W*BEATS-1:0]  i_readdata,
    output logic                     i_busywait,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [WORD_W-1:0]        mem_writedata,
    input  logic [WORD_W-1:0]        mem_readdata,
    input  logic                     mem_busywait
);

    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    arb_state_t          state;
    grant_t              last_grant;
    logic                issue;
    logic [WORD_W-1:0]   d_held;
    logic [BEAT_W-1:0]   beat;
    logic                last_beat;

    logic d_req, i_req;
    logic access_done, d_complete, beat_done, i_complete;
    logic d_deliver, i_deliver;

    assign d_req = d_read | d_write;
    assign i_req = i_read;

    // Memory stall is meaningless in the issue cycle, so completion needs at least one more.
    assign access_done = !issue && !mem_busywait;
    assign d_complete  = (state == D_ACC) && access_done;
    assign beat_done   = (state == I_ACC) && access_done;
    assign i_complete  = beat_done && last_beat;

    // A requester that withdrew keeps its old data; the memory access still runs to the end.
    assign d_deliver = d_complete && d_req;
    assign i_deliver = i_complete && i_req;

    assign d_busywait = d_req && !d_complete;
    assign i_busywait = i_req && !i_complete;
    assign d_readdata = d_deliver ? mem_readdata : d_held;

    assign mem_writedata = d_writedata;

    always_comb begin
        mem_address = '0;
        case (state)
            D_ACC:   mem_address = d_address;
            I_ACC:   mem_address = {i_address, beat};
            default: mem_address = '0;
        endcase
    end

    line_assembler #(
        .WORD_W (WORD_W),
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W)
    ) u_line (
        .clk       (CLK),
        .reset     (RESET),
        .capture   (beat_done),
        .deliver   (i_deliver),
        .word_in   (mem_readdata),
        .beat      (beat),
        .last_beat (last_beat),
        .line      (i_readdata)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            issue      <= 1'b0;
            last_grant <= GRANT_I;
            d_held     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req && (!i_req || last_grant == GRANT_I)) begin
                        state      <= D_ACC;
                        mem_write  <= d_write;
                        mem_read   <= !d_write;
                        issue      <= 1'b1;
                        last_grant <= GRANT_D;
                    end else if (i_req) begin
                        state      <= I_ACC;
                        mem_read   <= 1'b1;
                        mem_write  <= 1'b0;
                        issue      <= 1'b1;
                        last_grant <= GRANT_I;
                    end
                end
                D_ACC: begin
                    issue <= 1'b0;
                    if (d_complete) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (d_req) begin
                            d_held <= mem_readdata;
                        end
                    end
                end
                I_ACC: begin
                    issue <= beat_done && !last_beat;
                    if (i_complete) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    issue     <= 1'b0;
                end
            endcase
        end
    end

endmodule
